// File: rtl/pulse_tx_if.sv
// Request/pulse interface for pulse_tx. The master side raises requests.
// The slave side (the transmitter) drives the pulse line and status.
interface pulse_tx_if #(
  parameter int CNT_W = 4
);
  logic             req;
  logic             sig_out;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             overflow;

  modport master (output req, input sig_out, input busy, input pending, input overflow);
  modport slave  (input req, output sig_out, output busy, output pending, output overflow);
endinterface

// File: rtl/pulse_tx.sv
// pulse_tx: turns one-cycle requests into width-guaranteed pulses on a
// registered line. A remote 3-flop resynchronizer sees one clean rise and
// one clean fall per request. Requests that arrive while a pulse or gap is
// running are queued in a saturating counter. Requests beyond its depth
// are dropped and flagged.
//
//   state  | meaning
//   IDLE   | line low, nothing in flight
//   HIGH   | line high, timer counts the remaining high cycles
//   GAP    | line low, timer counts the remaining minimum low cycles
module pulse_tx #(
  parameter int HIGH_CYCLES = 3,
  parameter int GAP_CYCLES  = 3,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  pulse_tx_if.slave   bus
);
  localparam int MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC) + 1;

  localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state;
  logic [TMR_W-1:0] timer;
  logic             sig_q;
  logic             ovf_q;
  logic [CNT_W-1:0] pend_q;
  logic [CNT_W-1:0] pend_nxt;
  logic             launch;
  logic             accept;

  // A pulse may start from IDLE, or back-to-back at the end of a gap.
  // A launching request is never dropped, even when the queue is full,
  // because it is consumed in the same cycle.
  always_comb begin
    launch   = ((state == S_IDLE) || ((state == S_GAP) && (timer == '0)))
               && ((pend_q != '0) || bus.req);
    accept   = bus.req && ((pend_q != PEND_MAX) || launch);
    pend_nxt = pend_q;
    if (accept && !launch)
      pend_nxt = pend_q + 1'b1;
    else if (!accept && launch)
      pend_nxt = pend_q - 1'b1;
  end

  // Pulse sequencer: state, down-counting timer and the registered line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      timer <= '0;
      sig_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            state <= S_HIGH;
            timer <= HIGH_LOAD;
            sig_q <= 1'b1;
          end
        end
        S_HIGH: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state <= S_GAP;
            timer <= GAP_LOAD;
            sig_q <= 1'b0;
          end
        end
        S_GAP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (launch) begin
            state <= S_HIGH;
            timer <= HIGH_LOAD;
            sig_q <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
          sig_q <= 1'b0;
        end
      endcase
    end
  end

  // Pending queue count and the one-cycle drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      ovf_q  <= bus.req && !accept;
    end
  end

  assign bus.sig_out  = sig_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state != S_IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_pulse_tx.sv
// Bench for pulse_tx. It runs three instances side by side: defaults, a
// shallow queue (CNT_W=2), and 1/1 timing. Each instance is checked every
// cycle against a timeline model. In that model, a pulse launched at edge
// t owns the line for HIGH+GAP edges.
module tb_pulse_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_tx_if #(.CNT_W(4)) if_a ();
  pulse_tx_if #(.CNT_W(2)) if_b ();
  pulse_tx_if #(.CNT_W(4)) if_c ();

  pulse_tx #(.HIGH_CYCLES(3), .GAP_CYCLES(3), .CNT_W(4)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  pulse_tx #(.HIGH_CYCLES(3), .GAP_CYCLES(3), .CNT_W(2)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  pulse_tx #(.HIGH_CYCLES(1), .GAP_CYCLES(1), .CNT_W(4)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  typedef struct {
    int rst;
    int req;
    int sig;
    int busy;
    int pend;
    int ovf;
  } vec_t;

  vec_t tbl[$];

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;

  int hc[3] = '{3, 3, 1};
  int gc[3] = '{3, 3, 1};
  int mx[3] = '{15, 3, 15};
  string nm[3] = '{"a", "b", "c"};

  int   pend[3];
  int   tl[3];
  int   m_ovf[3];
  int   rises[3];
  int   prev_sig[3];
  int   act_sig[3];
  int   act_busy[3];
  int   act_pend[3];
  int   act_ovf[3];

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline reference: a launch is allowed once HIGH+GAP edges have passed
  // since the previous launch. The queue is a plain integer count.
  task automatic model_edge(input int i, input logic r_rst, input logic r);
    int can;
    int launch;
    int accept;
    if (r_rst) begin
      pend[i]  = 0;
      tl[i]    = -1000;
      m_ovf[i] = 0;
    end else begin
      can    = (cyc >= tl[i] + hc[i] + gc[i]) ? 1 : 0;
      launch = (can != 0 && (pend[i] > 0 || r)) ? 1 : 0;
      accept = (r && (pend[i] < mx[i] || launch != 0)) ? 1 : 0;
      pend[i]  = pend[i] + accept - launch;
      m_ovf[i] = (r && accept == 0) ? 1 : 0;
      if (launch != 0) tl[i] = cyc;
    end
  endtask

  task automatic step(input logic r_rst, input logic ra, input logic rb, input logic rc);
    logic rq[3];
    int   e_sig;
    int   e_busy;
    rq[0] = ra;
    rq[1] = rb;
    rq[2] = rc;
    rst = r_rst;
    if_a.req = ra;
    if_b.req = rb;
    if_c.req = rc;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i, r_rst, rq[i]);
    #1;
    act_sig[0] = int'(if_a.sig_out); act_busy[0] = int'(if_a.busy);
    act_pend[0] = int'(if_a.pending); act_ovf[0] = int'(if_a.overflow);
    act_sig[1] = int'(if_b.sig_out); act_busy[1] = int'(if_b.busy);
    act_pend[1] = int'(if_b.pending); act_ovf[1] = int'(if_b.overflow);
    act_sig[2] = int'(if_c.sig_out); act_busy[2] = int'(if_c.busy);
    act_pend[2] = int'(if_c.pending); act_ovf[2] = int'(if_c.overflow);
    for (int i = 0; i < 3; i++) begin
      e_sig  = ((cyc - tl[i]) < hc[i]) ? 1 : 0;
      e_busy = (((cyc - tl[i]) < hc[i] + gc[i]) || pend[i] != 0) ? 1 : 0;
      chk($sformatf("%s_sig", nm[i]), act_sig[i], e_sig);
      chk($sformatf("%s_busy", nm[i]), act_busy[i], e_busy);
      chk($sformatf("%s_pending", nm[i]), act_pend[i], pend[i]);
      chk($sformatf("%s_overflow", nm[i]), act_ovf[i], m_ovf[i]);
      if (act_sig[i] == 1 && prev_sig[i] == 0) rises[i]++;
      prev_sig[i] = act_sig[i];
    end
    cyc++;
  endtask

  task automatic add(input int r, input int q, input int s, input int b, input int p, input int o);
    vec_t v;
    v.rst = r; v.req = q; v.sig = s; v.busy = b; v.pend = p; v.ovf = o;
    tbl.push_back(v);
  endtask

  task automatic add_n(input int n, input int s, input int b, input int p);
    for (int k = 0; k < n; k++) add(0, 0, s, b, p, 0);
  endtask

  int r0;
  int ovf_seen;

  initial begin
    for (int i = 0; i < 3; i++) begin
      pend[i] = 0; tl[i] = -1000; m_ovf[i] = 0; rises[i] = 0; prev_sig[i] = 0;
    end
    if_a.req = 1'b0; if_b.req = 1'b0; if_c.req = 1'b0;

    // Reset with req high, then one request, then three back-to-back.
    add(1, 1, 0, 0, 0, 0);
    add_n(2, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add_n(2, 1, 1, 0);
    add_n(3, 0, 1, 0);
    add_n(2, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 1, 1, 1, 1, 0);
    add(0, 1, 1, 1, 2, 0);
    add_n(3, 0, 1, 2);
    add_n(3, 1, 1, 1);
    add_n(3, 0, 1, 1);
    add_n(3, 1, 1, 0);
    add_n(3, 0, 1, 0);
    add_n(1, 0, 0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].rst[0], tbl[k].req[0], 1'b0, 1'b0);
      chk($sformatf("tbl%0d_sig", k), act_sig[0], tbl[k].sig);
      chk($sformatf("tbl%0d_busy", k), act_busy[0], tbl[k].busy);
      chk($sformatf("tbl%0d_pending", k), act_pend[0], tbl[k].pend);
      chk($sformatf("tbl%0d_overflow", k), act_ovf[0], tbl[k].ovf);
    end

    // Shallow queue: the fifth back-to-back request is dropped.
    step(1, 0, 0, 0);
    r0 = rises[1];
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0);
      if (k == 3) chk("b_fill_pending", act_pend[1], 3);
      if (k == 3) chk("b_fill_ovf", act_ovf[1], 0);
      if (k == 4) chk("b_drop_ovf", act_ovf[1], 1);
    end
    step(0, 0, 0, 0);
    chk("b_drop_ovf_clear", act_ovf[1], 0);
    for (int k = 0; k < 30; k++) step(0, 0, 0, 0);
    chk("b_drop_pulses", rises[1] - r0, 4);

    // Full queue, request lands exactly as the gap ends: accepted.
    step(1, 0, 0, 0);
    r0 = rises[1];
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("b_edge_pending", act_pend[1], 3);
    chk("b_edge_ovf", act_ovf[1], 0);
    chk("b_edge_sig", act_sig[1], 1);
    for (int k = 0; k < 30; k++) step(0, 0, 0, 0);
    chk("b_edge_pulses", rises[1] - r0, 5);

    // Reset on the second high cycle of a pulse while two are queued.
    step(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("a_rst_pre_pending", act_pend[0], 2);
    step(0, 0, 0, 0);
    chk("a_rst_pre_sig", act_sig[0], 1);
    step(1, 0, 0, 0);
    chk("a_rst_sig", act_sig[0], 0);
    chk("a_rst_pending", act_pend[0], 0);
    chk("a_rst_busy", act_busy[0], 0);
    r0 = rises[0];
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0);
    chk("a_rst_no_pulses", rises[0] - r0, 0);
    step(0, 1, 0, 0);
    chk("a_rst_relaunch", act_sig[0], 1);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0);

    // 1/1 timing, request held for eight cycles.
    step(1, 0, 0, 0);
    r0 = rises[2];
    ovf_seen = 0;
    for (int k = 0; k < 18; k++) begin
      step(0, 0, 0, (k < 8) ? 1'b1 : 1'b0);
      if (act_ovf[2] != 0) ovf_seen = 1;
      if (k < 16) chk($sformatf("c_alt%0d", k), act_sig[2], (k % 2 == 0) ? 1 : 0);
    end
    chk("c_pulses", rises[2] - r0, 8);
    chk("c_no_ovf", ovf_seen, 0);

    // Random traffic on all three, with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 120; k++) step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
